// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter that gives the I-cache or the D-cache exclusive use of the
// memory port for a whole line fill (BURST_LEN beats) or a single write-through beat.
module cache_mem_arbiter #(
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned TYPE_W    = 3,
   parameter int unsigned BURST_LEN = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_creq,
   input  logic              i_cwrite,
   input  logic [DATA_W-1:0] i_caddr,
   input  logic [DATA_W-1:0] i_cin,
   input  logic [TYPE_W-1:0] i_ctype,
   output logic [DATA_W-1:0] i_cout,
   output logic              i_cwait,
   input  logic              d_creq,
   input  logic              d_cwrite,
   input  logic [DATA_W-1:0] d_caddr,
   input  logic [DATA_W-1:0] d_cin,
   input  logic [TYPE_W-1:0] d_ctype,
   output logic [DATA_W-1:0] d_cout,
   output logic              d_cwait,
   output logic              mreq,
   output logic              mwrite,
   output logic [DATA_W-1:0] maddr,
   output logic [DATA_W-1:0] min,
   output logic [TYPE_W-1:0] mtype,
   input  logic [DATA_W-1:0] mout,
   input  logic              mwait,
   output logic [1:0]        gnt
);

   localparam int unsigned CNT_W = $clog2(BURST_LEN) + 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BURST_LEN);

   typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

   state_t           state;
   logic             last;   // 1: D-cache owned the port most recently
   logic             op_wr;
   logic [CNT_W-1:0] cnt;

   logic             own_i, own_d, own_creq, beat, done;
   logic [CNT_W-1:0] cnt_inc;

   always_comb begin
      own_i    = (state == GNT_I);
      own_d    = (state == GNT_D);
      own_creq = (own_i & i_creq) | (own_d & d_creq);
      beat     = own_creq & ~mwait;
      cnt_inc  = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
      done     = beat & (op_wr | (cnt_inc == CNT_MAX));
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         last  <= 1'b1;
         op_wr <= 1'b0;
         cnt   <= '0;
         gnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (i_creq && (!d_creq || last)) begin
                  state <= GNT_I;
                  gnt   <= 2'b01;
                  last  <= 1'b0;
                  op_wr <= i_cwrite;
                  cnt   <= '0;
               end else if (d_creq) begin
                  state <= GNT_D;
                  gnt   <= 2'b10;
                  last  <= 1'b1;
                  op_wr <= d_cwrite;
                  cnt   <= '0;
               end
            end
            GNT_I, GNT_D: begin
               // An abandoned transaction releases without counting a beat.
               if (!own_creq || done) begin
                  state <= IDLE;
                  gnt   <= '0;
                  cnt   <= '0;
               end else if (beat) begin
                  cnt <= cnt_inc;
               end
            end
            default: begin
               state <= IDLE;
               gnt   <= '0;
               cnt   <= '0;
            end
         endcase
      end
   end

   always_comb begin
      mreq   = 1'b0;
      mwrite = 1'b0;
      maddr  = '0;
      min    = '0;
      mtype  = '0;
      if (own_i) begin
         mreq   = i_creq;
         mwrite = i_cwrite;
         maddr  = i_caddr;
         min    = i_cin;
         mtype  = i_ctype;
      end else if (own_d) begin
         mreq   = d_creq;
         mwrite = d_cwrite;
         maddr  = d_caddr;
         min    = d_cin;
         mtype  = d_ctype;
      end
   end

   always_comb begin
      i_cwait = own_i ? (i_creq & mwait) : i_creq;
      d_cwait = own_d ? (d_creq & mwait) : d_creq;
      i_cout  = (own_i & i_creq) ? mout : '0;
      d_cout  = (own_d & d_creq) ? mout : '0;
   end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench for cache_mem_arbiter: directed scenarios followed by random
// traffic, every cycle compared against a transaction-level ownership model.
module tb_cache_mem_arbiter;

   localparam int unsigned DATA_W    = 32;
   localparam int unsigned TYPE_W    = 3;
   localparam int unsigned BURST_LEN = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              i_creq, i_cwrite, d_creq, d_cwrite;
   logic [DATA_W-1:0] i_caddr, i_cin, d_caddr, d_cin;
   logic [TYPE_W-1:0] i_ctype, d_ctype;
   logic [DATA_W-1:0] i_cout, d_cout;
   logic              i_cwait, d_cwait;
   logic              mreq, mwrite, mwait;
   logic [DATA_W-1:0] maddr, min, mout;
   logic [TYPE_W-1:0] mtype;
   logic [1:0]        gnt;

   int checks = 0;
   int errors = 0;

   // Reference model: who owns the port, beats done, write flag captured at grant.
   int m_owner;   // 0 none, 1 I-cache, 2 D-cache
   int m_beats;
   bit m_last_d;
   bit m_wr;

   cache_mem_arbiter #(
      .DATA_W   (DATA_W),
      .TYPE_W   (TYPE_W),
      .BURST_LEN(BURST_LEN)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .i_creq  (i_creq),
      .i_cwrite(i_cwrite),
      .i_caddr (i_caddr),
      .i_cin   (i_cin),
      .i_ctype (i_ctype),
      .i_cout  (i_cout),
      .i_cwait (i_cwait),
      .d_creq  (d_creq),
      .d_cwrite(d_cwrite),
      .d_caddr (d_caddr),
      .d_cin   (d_cin),
      .d_ctype (d_ctype),
      .d_cout  (d_cout),
      .d_cwait (d_cwait),
      .mreq    (mreq),
      .mwrite  (mwrite),
      .maddr   (maddr),
      .min     (min),
      .mtype   (mtype),
      .mout    (mout),
      .mwait   (mwait),
      .gnt     (gnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_owner  = 0;
      m_beats  = 0;
      m_last_d = 1'b1;
      m_wr     = 1'b0;
   endtask

   task automatic model_step();
      logic creq;
      if (!rst) begin
         model_reset();
         return;
      end
      if (m_owner == 0) begin
         if (i_creq && d_creq) m_owner = m_last_d ? 1 : 2;
         else if (i_creq)      m_owner = 1;
         else if (d_creq)      m_owner = 2;
         if (m_owner != 0) begin
            m_last_d = (m_owner == 2);
            m_wr     = (m_owner == 1) ? i_cwrite : d_cwrite;
            m_beats  = 0;
         end
      end else begin
         creq = (m_owner == 1) ? i_creq : d_creq;
         if (!creq) m_owner = 0;
         else if (!mwait) begin
            m_beats++;
            if (m_beats >= (m_wr ? 1 : int'(BURST_LEN))) m_owner = 0;
         end
      end
   endtask

   task automatic check_all();
      logic              e_mreq, e_mwrite, e_icw, e_dcw;
      logic [DATA_W-1:0] e_maddr, e_min, e_icout, e_dcout;
      logic [TYPE_W-1:0] e_mtype;
      logic [1:0]        e_gnt;
      e_mreq = 0; e_mwrite = 0; e_maddr = '0; e_min = '0; e_mtype = '0;
      e_icw = i_creq; e_dcw = d_creq; e_icout = '0; e_dcout = '0; e_gnt = 2'b00;
      if (m_owner == 1) begin
         e_gnt = 2'b01; e_mreq = i_creq; e_mwrite = i_cwrite;
         e_maddr = i_caddr; e_min = i_cin; e_mtype = i_ctype;
         e_icw = i_creq & mwait; e_icout = i_creq ? mout : '0;
      end else if (m_owner == 2) begin
         e_gnt = 2'b10; e_mreq = d_creq; e_mwrite = d_cwrite;
         e_maddr = d_caddr; e_min = d_cin; e_mtype = d_ctype;
         e_dcw = d_creq & mwait; e_dcout = d_creq ? mout : '0;
      end
      chk("gnt", 32'(gnt), 32'(e_gnt));
      chk("mreq", 32'(mreq), 32'(e_mreq));
      chk("mwrite", 32'(mwrite), 32'(e_mwrite));
      chk("maddr", maddr, e_maddr);
      chk("min", min, e_min);
      chk("mtype", 32'(mtype), 32'(e_mtype));
      chk("i_cwait", 32'(i_cwait), 32'(e_icw));
      chk("d_cwait", 32'(d_cwait), 32'(e_dcw));
      chk("i_cout", i_cout, e_icout);
      chk("d_cout", d_cout, e_dcout);
   endtask

   task automatic tick();
      @(negedge clk);
      check_all();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic randomize_inputs(input int unsigned req_pct);
      i_creq   = ($urandom_range(0, 99) < req_pct);
      d_creq   = ($urandom_range(0, 99) < req_pct);
      i_cwrite = ($urandom_range(0, 9) < 3);
      d_cwrite = ($urandom_range(0, 9) < 3);
      i_caddr  = $urandom; i_cin = $urandom; i_ctype = TYPE_W'($urandom);
      d_caddr  = $urandom; d_cin = $urandom; d_ctype = TYPE_W'($urandom);
      mwait    = ($urandom_range(0, 9) < 3);
      mout     = $urandom;
   endtask

   task automatic clear_inputs();
      i_creq = 0; i_cwrite = 0; i_caddr = '0; i_cin = '0; i_ctype = '0;
      d_creq = 0; d_cwrite = 0; d_caddr = '0; d_cin = '0; d_ctype = '0;
      mwait = 0; mout = '0;
   endtask

   initial begin
      int gseq[$];
      logic [1:0] prev_gnt;
      int rel;

      rst = 1'b0;
      clear_inputs();
      model_reset();

      // Reset held with random traffic
      repeat (6) begin
         randomize_inputs(50);
         tick();
      end
      clear_inputs();
      #1;
      chk("rst_gnt", 32'(gnt), 0);
      chk("rst_mreq", 32'(mreq), 0);
      rst = 1'b1;

      // Simultaneous requests after reset: I read wins, D write follows
      i_creq = 1; i_caddr = 32'h40;
      d_creq = 1; d_cwrite = 1; d_caddr = 32'h8000_0004; d_cin = 32'hDEAD_BEEF;
      tick();
      for (int k = 1; k <= 4; k++) begin
         mout = 32'hB0 + k;
         #1;
         chk("sim_gnt_i", 32'(gnt), 1);
         chk("sim_dwait", 32'(d_cwait), 1);
         tick();
      end
      chk("sim_bubble", 32'(gnt), 0);
      chk("sim_dwait5", 32'(d_cwait), 1);
      i_creq = 0;
      tick();
      chk("sim_gnt_d", 32'(gnt), 2);
      chk("sim_min", min, 32'hDEAD_BEEF);
      chk("sim_mwrite", 32'(mwrite), 1);
      tick();
      chk("sim_rel", 32'(gnt), 0);
      clear_inputs();
      tick();

      // Single I-cache line fill
      i_creq = 1; i_caddr = 32'h0000_0100;
      tick();
      for (int k = 0; k < 4; k++) begin
         mout = 32'hA0 + k;
         #1;
         chk("rd_gnt", 32'(gnt), 1);
         chk("rd_maddr", maddr, 32'h100);
         chk("rd_cout", i_cout, 32'hA0 + k);
         tick();
      end
      chk("rd_release", 32'(gnt), 0);
      i_creq = 0;
      tick();

      // Round-robin with both caches reading continuously
      i_creq = 1; d_creq = 1; i_caddr = 32'h200; d_caddr = 32'h300;
      prev_gnt = 2'b00;
      for (int k = 0; k < 30; k++) begin
         mout = $urandom;
         tick();
         if (gnt != 2'b00 && prev_gnt == 2'b00) gseq.push_back(int'(gnt));
         prev_gnt = gnt;
      end
      chk("rr_count", 32'(gseq.size() >= 4), 1);
      for (int k = 0; k < 4 && k < gseq.size(); k++)
         chk("rr_order", 32'(gseq[k]), (k % 2 == 0) ? 2 : 1);
      clear_inputs();
      tick();
      tick();

      // D read with three stall cycles before each beat
      d_creq = 1; d_caddr = 32'h400;
      rel = 0;
      for (int k = 0; k < 40; k++) begin
         mwait = (k > 0 && (k % 4) == 0) ? 1'b0 : 1'b1;
         mout  = $urandom;
         tick();
         if (k > 0 && gnt == 2'b00) begin
            rel = k + 1;
            break;
         end
      end
      chk("stall_release", rel, 17);
      clear_inputs();
      tick();

      // I abandons after two beats; pending D is served next
      i_creq = 1; i_caddr = 32'h500;
      tick();
      d_creq = 1; d_caddr = 32'h600;
      tick();
      tick();
      i_creq = 0;
      tick();
      chk("abort_idle", 32'(gnt), 0);
      tick();
      chk("abort_gnt_d", 32'(gnt), 2);
      tick();

      // Asynchronous reset in the middle of the D burst
      #2 rst = 1'b0;
      #1;
      chk("midrst_mreq", 32'(mreq), 0);
      chk("midrst_gnt", 32'(gnt), 0);
      model_reset();
      d_creq = 0;
      tick();
      rst = 1'b1;
      tick();

      // Random traffic
      for (int k = 0; k < 1500; k++) begin
         randomize_inputs(85);
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
